// File: rtl/frame_stream_loader_pkg.sv
// frame_stream_loader_pkg: default frame geometry shared by the loader and the
// VGA-side blocks, plus the loader FSM state encoding.
package frame_stream_loader_pkg;
    localparam int DFLT_FB_W   = 80;
    localparam int DFLT_FB_H   = 60;
    localparam int DFLT_FB_BPP = 3;
    localparam int DFLT_CNT_W  = 16;

    typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;

    function automatic int fb_bits(input int w, input int h, input int bpp);
        return w * h * bpp;
    endfunction
endpackage

// File: rtl/frame_stream_loader_pos_counter.sv
// frame_pos_counter: raster col/row position with a running linear bit index,
// so packed-bus addressing needs no multiplier.
module frame_pos_counter
    import frame_stream_loader_pkg::*;
#(
    parameter int FB_W   = DFLT_FB_W,
    parameter int FB_H   = DFLT_FB_H,
    parameter int FB_BPP = DFLT_FB_BPP,
    localparam int IDX_W = $clog2(fb_bits(FB_W, FB_H, FB_BPP))
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    output logic [IDX_W-1:0] idx,
    output logic             last
);
    localparam int COL_W = (FB_W > 1) ? $clog2(FB_W) : 1;
    localparam int ROW_W = (FB_H > 1) ? $clog2(FB_H) : 1;

    logic [COL_W-1:0] col_q, col_d, col_b;
    logic [ROW_W-1:0] row_q, row_d, row_b;
    logic [IDX_W-1:0] idx_q, idx_d, idx_b;
    logic             eol;

    // clear and advance together land on position 1 (the beat after a start-of-frame)
    always_comb begin
        col_b = clear ? '0 : col_q;
        row_b = clear ? '0 : row_q;
        idx_b = clear ? '0 : idx_q;
        eol   = col_b == COL_W'(FB_W - 1);
        col_d = advance ? (eol ? '0 : col_b + 1'b1) : col_b;
        row_d = (advance && eol) ? row_b + 1'b1 : row_b;
        idx_d = advance ? idx_b + IDX_W'(FB_BPP) : idx_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
            idx_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            idx_q <= idx_d;
        end
    end

    assign idx  = idx_q;
    assign last = (col_q == COL_W'(FB_W - 1)) && (row_q == ROW_W'(FB_H - 1));
endmodule

// File: rtl/frame_stream_loader.sv
// frame_stream_loader: unpacks a serial row-major pixel stream into a back
// buffer and swaps it onto the packed front bus only when a frame completes.
module frame_stream_loader
    import frame_stream_loader_pkg::*;
#(
    parameter int FB_W   = DFLT_FB_W,
    parameter int FB_H   = DFLT_FB_H,
    parameter int FB_BPP = DFLT_FB_BPP,
    parameter int CNT_W  = DFLT_CNT_W,
    localparam int FB_BITS = fb_bits(FB_W, FB_H, FB_BPP),
    localparam int IDX_W   = $clog2(FB_BITS)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sof,
    input  logic [FB_BPP-1:0]  in_pix,
    output logic [FB_BITS-1:0] pixel,
    output logic               frame_done,
    output logic               err_sync,
    output logic [CNT_W-1:0]   frame_cnt
);
    state_t             state_q, state_d;
    logic [FB_BITS-1:0] back_q, back_d, pixel_q, pixel_d;
    logic               frame_done_q, frame_done_d, err_sync_q, err_sync_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic               beat, sof_beat, fill, pos_clear, pos_adv, pos_last;
    logic [IDX_W-1:0]   pos_idx, wr_idx;

    frame_pos_counter #(.FB_W(FB_W), .FB_H(FB_H), .FB_BPP(FB_BPP)) u_pos (
        .clk     (clk),
        .rst_n   (clr),
        .clear   (pos_clear),
        .advance (pos_adv),
        .idx     (pos_idx),
        .last    (pos_last)
    );

    assign in_ready = state_q != COMMIT;
    assign beat     = in_valid && in_ready;
    assign sof_beat = beat && in_sof;
    assign fill     = state_q == FILL;
    assign wr_idx   = in_sof ? '0 : pos_idx;

    // a start-of-frame beat always restarts at pixel 0, in IDLE and mid-frame alike
    always_comb begin
        back_d       = back_q;
        pixel_d      = pixel_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;
        err_sync_d   = fill && sof_beat;
        pos_clear    = sof_beat || (fill && beat && pos_last);
        pos_adv      = sof_beat || (fill && beat && !pos_last);
        state_d      = state_q;
        if (sof_beat || (fill && beat)) back_d[wr_idx +: FB_BPP] = in_pix;
        case (state_q)
            IDLE:    state_d = sof_beat ? FILL : IDLE;
            FILL:    state_d = (beat && !in_sof && pos_last) ? COMMIT : FILL;
            COMMIT: begin
                pixel_d      = back_q;
                frame_done_d = 1'b1;
                frame_cnt_d  = frame_cnt_q + 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q      <= IDLE;
            back_q       <= '0;
            pixel_q      <= '0;
            frame_done_q <= 1'b0;
            err_sync_q   <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            back_q       <= back_d;
            pixel_q      <= pixel_d;
            frame_done_q <= frame_done_d;
            err_sync_q   <= err_sync_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign pixel      = pixel_q;
    assign frame_done = frame_done_q;
    assign err_sync   = err_sync_q;
    assign frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_frame_stream_loader.sv
// tb_frame_stream_loader: scoreboard bench for the full-size loader and a tiny
// 4x2 instance used to exercise frame counter wrap.
module tb_frame_stream_loader;
    localparam int W = 80, H = 60, BPP = 3, CW = 16, BITS = W * H * BPP;
    localparam int SW = 4, SH = 2, SCW = 2, SBITS = SW * SH * BPP;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            clr = 1'b1;
    logic            in_valid = 1'b0, in_sof = 1'b0, in_ready;
    logic [BPP-1:0]  in_pix = '0;
    logic [BITS-1:0] pixel;
    logic            frame_done, err_sync;
    logic [CW-1:0]   frame_cnt;

    logic             s_valid = 1'b0, s_sof = 1'b0, s_ready;
    logic [BPP-1:0]   s_pix = '0;
    logic [SBITS-1:0] s_pixel;
    logic             s_done, s_err;
    logic [SCW-1:0]   s_cnt;

    frame_stream_loader dut (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
        .in_pix(in_pix), .pixel(pixel), .frame_done(frame_done), .err_sync(err_sync),
        .frame_cnt(frame_cnt)
    );

    frame_stream_loader #(.FB_W(SW), .FB_H(SH), .FB_BPP(BPP), .CNT_W(SCW)) dut_s (
        .clk(clk), .clr(clr), .in_valid(s_valid), .in_ready(s_ready), .in_sof(s_sof),
        .in_pix(s_pix), .pixel(s_pixel), .frame_done(s_done), .err_sync(s_err),
        .frame_cnt(s_cnt)
    );

    logic [BITS-1:0]  m_back;
    int               m_col, m_row, m_cnt;
    bit               m_active;
    logic [BITS-1:0]  exp_pix_q[$], obs_pix_q[$];
    int               exp_cnt_q[$], obs_cnt_q[$];
    logic [SBITS-1:0] s_exp_q[$], s_obs_q[$];
    int               s_exp_cnt_q[$], s_obs_cnt_q[$];
    int               cyc, done_seen, err_seen, ready_low, last_done_cyc, last_err_cyc;
    int               passed = 0, total = 0;

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (frame_done) begin
            done_seen++;
            last_done_cyc = cyc;
            obs_pix_q.push_back(pixel);
            obs_cnt_q.push_back(int'(frame_cnt));
        end
        if (err_sync) begin
            err_seen++;
            last_err_cyc = cyc;
        end
        if (!in_ready) ready_low++;
        if (s_done) begin
            s_obs_q.push_back(s_pixel);
            s_obs_cnt_q.push_back(int'(s_cnt));
        end
    endtask

    task automatic model_accept(input logic sof, input logic [BPP-1:0] pix);
        if (sof) begin
            m_back[BPP-1:0] = pix;
            m_col = 1;
            m_row = 0;
            m_active = 1'b1;
        end else if (m_active) begin
            m_back[(m_row * W + m_col) * BPP +: BPP] = pix;
            if (m_col == W - 1 && m_row == H - 1) begin
                m_cnt++;
                exp_pix_q.push_back(m_back);
                exp_cnt_q.push_back(m_cnt % (1 << CW));
                m_active = 1'b0;
            end else if (m_col == W - 1) begin
                m_col = 0;
                m_row++;
            end else m_col++;
        end
    endtask

    task automatic beat(input logic sof, input logic [BPP-1:0] pix);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_sof = sof;
        in_pix = pix;
        for (int t = 0; t < 4 && !acc; t++) begin
            acc = in_ready;
            cycle();
        end
        if (acc) model_accept(sof, pix);
        else begin
            total++;
            $display("FAIL beat_accept: in_ready stayed %0b for 4 cycles, required 1", in_ready);
        end
    endtask

    task automatic wait_commit();
        in_valid = 1'b0;
        in_sof = 1'b0;
        for (int t = 0; t < 20 && obs_pix_q.size() < exp_pix_q.size(); t++) cycle();
    endtask

    task automatic do_reset();
        clr = 1'b0;
        in_valid = 1'b0;
        s_valid = 1'b0;
        m_back = '0;
        m_active = 1'b0;
        m_cnt = 0;
        exp_pix_q.delete(); obs_pix_q.delete(); exp_cnt_q.delete(); obs_cnt_q.delete();
        repeat (2) cycle();
        clr = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        #3 clr = 1'b0;
        #1;
        total++;
        if (pixel !== '0 || frame_cnt !== '0 || frame_done !== 1'b0 || err_sync !== 1'b0
            || in_ready !== 1'b1 || s_pixel !== '0 || s_cnt !== '0)
            $display("FAIL reset_state: cnt=%0d done=%0b err=%0b rdy=%0b pix_ones=%0d, required 0 0 0 1 0",
                     frame_cnt, frame_done, err_sync, in_ready, $countones(pixel));
        else passed++;
        do_reset();
    endtask

    task automatic test_full_frame();
        int d0 = done_seen, r0 = ready_low, bad = 0;
        logic [BITS-1:0] op, ep;
        int oc, ec;
        beat(1'b1, 3'd0);
        for (int k = 1; k < W * H; k++) beat(1'b0, BPP'(k % 8));
        wait_commit();
        total++;
        if (done_seen - d0 !== 1) $display("FAIL t1_done_count: got %0d, required 1", done_seen - d0);
        else passed++;
        total++;
        if (ready_low - r0 !== 1) $display("FAIL t1_ready_low: got %0d cycles, required 1", ready_low - r0);
        else passed++;
        for (int j = 0; j < H; j++)
            for (int i = 0; i < W; i++)
                if (pixel[(j * W + i) * BPP +: BPP] !== BPP'((j * W + i) % 8)) bad++;
        total++;
        if (bad != 0) $display("FAIL t1_ramp_pixels: %0d wrong pixels, required 0", bad);
        else passed++;
        total++;
        if (obs_pix_q.size() == 0 || exp_pix_q.size() == 0)
            $display("FAIL t1_scoreboard: observed %0d frames, required %0d", obs_pix_q.size(), exp_pix_q.size());
        else begin
            op = obs_pix_q.pop_front(); ep = exp_pix_q.pop_front();
            oc = obs_cnt_q.pop_front(); ec = exp_cnt_q.pop_front();
            if (op !== ep || oc !== ec)
                $display("FAIL t1_scoreboard: cnt=%0d diffbits=%0d, required cnt=%0d diffbits=0", oc, $countones(op ^ ep), ec);
            else passed++;
        end
    endtask

    task automatic test_pre_sof_drop();
        logic [BPP-1:0]  two = 3'd2;
        logic [BITS-1:0] op, ep;
        int oc, ec;
        do_reset();
        repeat (10) beat(1'b0, 3'd7);
        beat(1'b1, two);
        for (int k = 1; k < W * H; k++) beat(1'b0, two);
        wait_commit();
        total++;
        if (pixel !== {(W * H){two}} || frame_cnt !== CW'(1))
            $display("FAIL t2_all_code2: cnt=%0d diffbits=%0d, required cnt=1 diffbits=0",
                     frame_cnt, $countones(pixel ^ {(W * H){two}}));
        else passed++;
        total++;
        if (obs_pix_q.size() == 0 || exp_pix_q.size() == 0)
            $display("FAIL t2_scoreboard: observed %0d frames, required %0d", obs_pix_q.size(), exp_pix_q.size());
        else begin
            op = obs_pix_q.pop_front(); ep = exp_pix_q.pop_front();
            oc = obs_cnt_q.pop_front(); ec = exp_cnt_q.pop_front();
            if (op !== ep || oc !== ec)
                $display("FAIL t2_scoreboard: cnt=%0d diffbits=%0d, required cnt=%0d diffbits=0", oc, $countones(op ^ ep), ec);
            else passed++;
        end
    endtask

    task automatic test_gaps_double_buffer();
        logic [BPP-1:0] five = 3'd5, three = 3'd3;
        int d0 = done_seen;
        beat(1'b1, five);
        for (int k = 1; k < W * H; k++) beat(1'b0, five);
        wait_commit();
        beat(1'b1, three);
        for (int k = 1; k < W * H - 1; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) cycle();
            end
            beat(1'b0, three);
        end
        total++;
        if (pixel !== {(W * H){five}} || done_seen - d0 !== 1)
            $display("FAIL t3_hold_front: done=%0d diffbits=%0d, required done=1 diffbits=0",
                     done_seen - d0, $countones(pixel ^ {(W * H){five}}));
        else passed++;
        beat(1'b0, three);
        wait_commit();
        total++;
        if (pixel !== {(W * H){three}} || done_seen - d0 !== 2)
            $display("FAIL t3_swap_front: done=%0d diffbits=%0d, required done=2 diffbits=0",
                     done_seen - d0, $countones(pixel ^ {(W * H){three}}));
        else passed++;
        total++;
        if (obs_pix_q.size() != 2 || exp_pix_q.size() != 2 || obs_pix_q[1] !== exp_pix_q[1] || obs_cnt_q[1] !== exp_cnt_q[1])
            $display("FAIL t3_scoreboard: observed %0d frames, required %0d matching", obs_pix_q.size(), exp_pix_q.size());
        else passed++;
        obs_pix_q.delete(); exp_pix_q.delete(); obs_cnt_q.delete(); exp_cnt_q.delete();
    endtask

    task automatic test_resync();
        int d0 = done_seen, e0 = err_seen, c_rs;
        logic [BITS-1:0] op, ep;
        int oc, ec;
        beat(1'b1, 3'd1);
        for (int k = 1; k < 2000; k++) beat(1'b0, BPP'(k % 8));
        beat(1'b1, 3'd6);
        c_rs = cyc;
        for (int k = 1; k < W * H; k++) beat(1'b0, BPP'((k * 3) % 8));
        wait_commit();
        total++;
        if (err_seen - e0 !== 1 || last_err_cyc !== c_rs)
            $display("FAIL t4_err_sync: pulses=%0d at cycle %0d, required 1 at %0d", err_seen - e0, last_err_cyc, c_rs);
        else passed++;
        total++;
        if (done_seen - d0 !== 1 || last_done_cyc - c_rs !== W * H)
            $display("FAIL t4_done_timing: done=%0d offset=%0d, required 1 at %0d", done_seen - d0, last_done_cyc - c_rs, W * H);
        else passed++;
        total++;
        if (obs_pix_q.size() == 0 || exp_pix_q.size() == 0)
            $display("FAIL t4_scoreboard: observed %0d frames, required %0d", obs_pix_q.size(), exp_pix_q.size());
        else begin
            op = obs_pix_q.pop_front(); ep = exp_pix_q.pop_front();
            oc = obs_cnt_q.pop_front(); ec = exp_cnt_q.pop_front();
            if (op !== ep || oc !== ec)
                $display("FAIL t4_scoreboard: cnt=%0d diffbits=%0d, required cnt=%0d diffbits=0", oc, $countones(op ^ ep), ec);
            else passed++;
        end
    endtask

    task automatic test_async_clear();
        logic [BITS-1:0] op, ep;
        int oc, ec;
        beat(1'b1, 3'd4);
        for (int k = 1; k < 3000; k++) beat(1'b0, BPP'($urandom));
        in_valid = 1'b0;
        clr = 1'b0;
        #1;
        total++;
        if (pixel !== '0 || frame_cnt !== '0)
            $display("FAIL t5_async_clear: cnt=%0d pix_ones=%0d, required 0 0", frame_cnt, $countones(pixel));
        else passed++;
        clr = 1'b1;
        do_reset();
        beat(1'b1, BPP'($urandom));
        for (int k = 1; k < W * H; k++) beat(1'b0, BPP'($urandom));
        wait_commit();
        total++;
        if (obs_pix_q.size() == 0 || exp_pix_q.size() == 0)
            $display("FAIL t5_scoreboard: observed %0d frames, required %0d", obs_pix_q.size(), exp_pix_q.size());
        else begin
            op = obs_pix_q.pop_front(); ep = exp_pix_q.pop_front();
            oc = obs_cnt_q.pop_front(); ec = exp_cnt_q.pop_front();
            if (op !== ep || oc !== 1 || ec !== 1)
                $display("FAIL t5_scoreboard: cnt=%0d diffbits=%0d, required cnt=1 diffbits=0", oc, $countones(op ^ ep));
            else passed++;
        end
    endtask

    task automatic test_small_wrap();
        logic [SBITS-1:0] v, op, ep;
        int oc, ec;
        for (int f = 0; f < 5; f++) begin
            v = SBITS'($urandom);
            for (int b = 0; b < SW * SH; b++) begin
                s_valid = 1'b1;
                s_sof = (b == 0);
                s_pix = v[b * BPP +: BPP];
                cycle();
            end
            s_valid = 1'b0;
            s_sof = 1'b0;
            s_exp_q.push_back(v);
            s_exp_cnt_q.push_back((f + 1) % 4);
            repeat (3) cycle();
            total++;
            if (s_obs_q.size() == 0)
                $display("FAIL small_frame%0d: no frame_done, required one", f);
            else begin
                op = s_obs_q.pop_front(); ep = s_exp_q.pop_front();
                oc = s_obs_cnt_q.pop_front(); ec = s_exp_cnt_q.pop_front();
                if (op !== ep || oc !== ec)
                    $display("FAIL small_frame%0d: pixel=%h cnt=%0d, required pixel=%h cnt=%0d", f, op, oc, ep, ec);
                else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_pre_sof_drop();
        test_gaps_double_buffer();
        test_resync();
        test_async_clear();
        test_small_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
